// File: rtl/l2_cache_control_pkg.sv
// Shared types for the 2-way write-back L2 cache controller.
package l2_cache_control_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } lc3b_l2_state_t;

  localparam int unsigned L2_CNT_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/l2_cache_control_sat_counter.sv
// Saturating event counter: increments on inc, holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic             w_full;

  assign w_full = &r_count;
  assign count  = r_count;

  // Count register with saturation at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (inc && !w_full) begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/l2_cache_control.sv
// Control FSM for the 2-way write-back L2: serves hits in IDLE, writes back
// dirty victims, fills lines from physical memory, and counts hits/misses/writebacks.
module l2_cache_control
  import l2_cache_control_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = L2_CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 hit,
  input  logic                 lru,
  input  logic                 valid0,
  input  logic                 valid1,
  input  logic                 dirty0,
  input  logic                 dirty1,
  output logic                 pmem_addressmux_sel,
  output logic                 datawritemux_sel,
  output logic                 valid0_write,
  output logic                 valid1_write,
  output logic                 dirty0_write,
  output logic                 dirty1_write,
  output logic                 tag0_write,
  output logic                 tag1_write,
  output logic                 data0_write,
  output logic                 data1_write,
  output logic                 valid0_in,
  output logic                 valid1_in,
  output logic                 dirty0_in,
  output logic                 dirty1_in,
  output logic                 lru_write,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  lc3b_l2_state_t r_state;
  lc3b_l2_state_t w_next;
  logic           w_req;
  logic           w_vdirty;
  logic           w_hit_inc;
  logic           w_miss_inc;
  logic           w_wb_inc;

  assign w_req    = mem_read | mem_write;
  assign w_vdirty = lru ? (dirty1 & valid1) : (dirty0 & valid0);

  assign w_hit_inc  = (r_state == IDLE) & w_req & hit;
  assign w_miss_inc = (r_state == IDLE) & w_req & ~hit;
  assign w_wb_inc   = (r_state == WRITEBACK) & pmem_resp;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a dropped request still lets the pmem transfer and fill finish
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req && !hit) begin
          w_next = w_vdirty ? WRITEBACK : FETCH;
        end else begin
          w_next = IDLE;
        end
      end
      WRITEBACK: begin
        if (pmem_resp) begin
          w_next = FETCH;
        end else begin
          w_next = WRITEBACK;
        end
      end
      FETCH: begin
        if (pmem_resp) begin
          w_next = IDLE;
        end else begin
          w_next = FETCH;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Output decode; the fill writes only the victim way, on the pmem_resp cycle
  always_comb begin
    mem_resp            = 1'b0;
    pmem_read           = 1'b0;
    pmem_write          = 1'b0;
    pmem_addressmux_sel = 1'b0;
    datawritemux_sel    = 1'b0;
    valid0_write        = 1'b0;
    valid1_write        = 1'b0;
    dirty0_write        = 1'b0;
    dirty1_write        = 1'b0;
    tag0_write          = 1'b0;
    tag1_write          = 1'b0;
    data0_write         = 1'b0;
    data1_write         = 1'b0;
    valid0_in           = 1'b0;
    valid1_in           = 1'b0;
    dirty0_in           = 1'b0;
    dirty1_in           = 1'b0;
    lru_write           = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req && hit) begin
          mem_resp  = 1'b1;
          lru_write = 1'b1;
        end else begin
          mem_resp  = 1'b0;
        end
      end
      WRITEBACK: begin
        pmem_addressmux_sel = 1'b1;
        pmem_write          = 1'b1;
      end
      FETCH: begin
        pmem_read        = 1'b1;
        datawritemux_sel = 1'b1;
        if (pmem_resp && lru) begin
          data1_write  = 1'b1;
          tag1_write   = 1'b1;
          valid1_write = 1'b1;
          valid1_in    = 1'b1;
          dirty1_write = 1'b1;
        end else if (pmem_resp) begin
          data0_write  = 1'b1;
          tag0_write   = 1'b1;
          valid0_write = 1'b1;
          valid0_in    = 1'b1;
          dirty0_write = 1'b1;
        end else begin
          data0_write  = 1'b0;
        end
      end
      default: begin
        mem_resp = 1'b0;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_hit_inc),
    .count   (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_miss_inc),
    .count   (miss_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_wb_inc),
    .count   (wb_count)
  );

endmodule

// File: tb/tb_l2_cache_control.sv
// Directed bench for l2_cache_control; a second 2-bit-counter instance shares
// the stimulus so counter saturation can be observed.
module tb_l2_cache_control;

  logic clk = 1'b0;
  logic reset_n;
  logic mem_read, mem_write, pmem_resp, hit, lru;
  logic valid0, valid1, dirty0, dirty1;

  logic mem_resp, pmem_read, pmem_write, pmem_addressmux_sel, datawritemux_sel;
  logic valid0_write, valid1_write, dirty0_write, dirty1_write;
  logic tag0_write, tag1_write, data0_write, data1_write;
  logic valid0_in, valid1_in, dirty0_in, dirty1_in, lru_write;
  logic [15:0] hit_count, miss_count, wb_count;

  logic s_mem_resp, s_pmem_read, s_pmem_write, s_amux, s_dmux;
  logic s_v0w, s_v1w, s_d0w, s_d1w, s_t0w, s_t1w, s_da0w, s_da1w;
  logic s_v0i, s_v1i, s_d0i, s_d1i, s_lruw;
  logic [1:0] s_hit_count, s_miss_count, s_wb_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  l2_cache_control #(.CNT_WIDTH(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .hit(hit), .lru(lru), .valid0(valid0), .valid1(valid1),
    .dirty0(dirty0), .dirty1(dirty1), .pmem_addressmux_sel(pmem_addressmux_sel),
    .datawritemux_sel(datawritemux_sel), .valid0_write(valid0_write),
    .valid1_write(valid1_write), .dirty0_write(dirty0_write), .dirty1_write(dirty1_write),
    .tag0_write(tag0_write), .tag1_write(tag1_write), .data0_write(data0_write),
    .data1_write(data1_write), .valid0_in(valid0_in), .valid1_in(valid1_in),
    .dirty0_in(dirty0_in), .dirty1_in(dirty1_in), .lru_write(lru_write),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  l2_cache_control #(.CNT_WIDTH(2)) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(s_mem_resp), .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
    .pmem_resp(pmem_resp), .hit(hit), .lru(lru), .valid0(valid0), .valid1(valid1),
    .dirty0(dirty0), .dirty1(dirty1), .pmem_addressmux_sel(s_amux),
    .datawritemux_sel(s_dmux), .valid0_write(s_v0w), .valid1_write(s_v1w),
    .dirty0_write(s_d0w), .dirty1_write(s_d1w), .tag0_write(s_t0w), .tag1_write(s_t1w),
    .data0_write(s_da0w), .data1_write(s_da1w), .valid0_in(s_v0i), .valid1_in(s_v1i),
    .dirty0_in(s_d0i), .dirty1_in(s_d1i), .lru_write(s_lruw),
    .hit_count(s_hit_count), .miss_count(s_miss_count), .wb_count(s_wb_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge so inputs change and outputs are sampled mid-cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0; hit = 1'b0; lru = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0; dirty0 = 1'b0; dirty1 = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    #12;
    check("rst_mem_resp", {31'd0, mem_resp}, 32'd0);
    check("rst_pmem_rw", {30'd0, pmem_read, pmem_write}, 32'd0);
    check("rst_counts", {hit_count, miss_count} | {16'd0, wb_count}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // 1: read hit in way0
    mem_read = 1'b1; hit = 1'b1; valid0 = 1'b1;
    #1;
    check("t1_mem_resp", {31'd0, mem_resp}, 32'd1);
    check("t1_lru_write", {31'd0, lru_write}, 32'd1);
    check("t1_no_pmem", {30'd0, pmem_read, pmem_write}, 32'd0);
    check("t1_no_arrays", {24'd0, data0_write, data1_write, tag0_write, tag1_write,
                           valid0_write, valid1_write, dirty0_write, dirty1_write}, 32'd0);
    tick();
    idle_inputs();
    check("t1_hit_count", {16'd0, hit_count}, 32'd1);

    // 2: read miss, clean victim in way1
    mem_read = 1'b1; lru = 1'b1; valid1 = 1'b1; valid0 = 1'b1;
    #1;
    check("t2_idle_miss_resp", {31'd0, mem_resp}, 32'd0);
    tick();
    check("t2_miss_count", {16'd0, miss_count}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("t2_fetch_ctl", {27'd0, pmem_read, pmem_write, pmem_addressmux_sel,
                             datawritemux_sel, data1_write}, 32'b10010);
      tick();
    end
    pmem_resp = 1'b1;
    #1;
    check("t2_fill_way1", {24'd0, data1_write, tag1_write, valid1_write, valid1_in,
                           dirty1_write, dirty1_in, data0_write, tag0_write}, 32'b11111000);
    check("t2_pmem_read", {31'd0, pmem_read}, 32'd1);
    tick();
    pmem_resp = 1'b0; hit = 1'b1;
    #1;
    check("t2_resp_after_fill", {30'd0, mem_resp, pmem_read}, 32'b10);
    tick();
    idle_inputs();
    check("t2_counts", {hit_count, miss_count}, {16'd2, 16'd1});

    // 3: write miss, dirty victim in way0
    mem_write = 1'b1; lru = 1'b0; valid0 = 1'b1; dirty0 = 1'b1;
    tick();
    check("t3_miss_count", {16'd0, miss_count}, 32'd2);
    for (int i = 0; i < 2; i++) begin
      check("t3_wb_ctl", {29'd0, pmem_write, pmem_read, pmem_addressmux_sel}, 32'b101);
      tick();
    end
    pmem_resp = 1'b1;
    #1;
    check("t3_wb_before_edge", {16'd0, wb_count}, 32'd0);
    tick();
    pmem_resp = 1'b0;
    #1;
    check("t3_wb_count", {16'd0, wb_count}, 32'd1);
    check("t3_fetch_ctl", {29'd0, pmem_read, pmem_write, pmem_addressmux_sel}, 32'b100);
    tick();
    pmem_resp = 1'b1;
    #1;
    check("t3_fill_way0", {29'd0, data0_write, dirty0_in, data1_write}, 32'b100);
    tick();
    pmem_resp = 1'b0; dirty0 = 1'b0; hit = 1'b1;
    #1;
    check("t3_resp", {31'd0, mem_resp}, 32'd1);
    tick();
    idle_inputs();
    check("t3_counts", {hit_count, miss_count}, {16'd3, 16'd2});

    // 4: request dropped during FETCH
    mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    #1;
    check("t4_fetch_held", {30'd0, pmem_read, mem_resp}, 32'b10);
    pmem_resp = 1'b1;
    #1;
    check("t4_fill", {29'd0, data0_write, valid0_in, mem_resp}, 32'b110);
    tick();
    pmem_resp = 1'b0; hit = 1'b1;
    #1;
    check("t4_idle_no_resp", {29'd0, pmem_read, pmem_write, mem_resp}, 32'd0);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    #1;
    check("t4_pmem_resp_ignored", {30'd0, pmem_read, pmem_write}, 32'd0);
    check("t4_counts", {miss_count, wb_count}, {16'd3, 16'd1});
    idle_inputs();

    // 5: reset during WRITEBACK
    mem_write = 1'b1; lru = 1'b1; valid1 = 1'b1; dirty1 = 1'b1;
    tick();
    check("t5_in_wb", {31'd0, pmem_write}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_pmem", {30'd0, pmem_write, pmem_read}, 32'd0);
    check("t5_counts_clr", {hit_count, miss_count | wb_count}, 32'd0);
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("t5_idle", {30'd0, pmem_write, pmem_read}, 32'd0);

    // 6: five hits; 2-bit counter saturates at 3
    mem_read = 1'b1; hit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    idle_inputs();
    check("t6_hit16", {16'd0, hit_count}, 32'd5);
    check("t6_hit_sat", {30'd0, s_hit_count}, 32'd3);
    check("t6_miss_sat", {30'd0, s_miss_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
